// File: rtl/smt_fetch_unit.sv
// smt_fetch_unit
//   Multithreaded instruction-fetch stage. Each hardware thread owns a circular
//   fetch instruction queue (FIQ). One thread per cycle is offered to the
//   instruction memory as a BUS_LOAD of its PC line. Tagged replies fill the
//   waiting entries, and up to DP_NUM ready instructions of one thread are
//   offered to Dispatch each cycle. A branch mispredict flushes a thread's queue
//   and redirects its PC.
//
// Handshakes (both are offer/accept within one cycle):
//   fetch    : if_ic_command_o=BUS_LOAD is the offer. ic_response_i!=0 in the same
//              cycle accepts it, and its value is the tag the reply will carry.
//              A zero response means "refused": the same request is offered again.
//   dispatch : fiq_dp_avail_num_o is the offer. dp_num_i (<= avail_num) is how many
//              of the listed instructions Dispatch takes at the coming edge.
//
// Ports
//   clk_i, rst_i                        clock, async active-high reset
//   pc_en_i[t]                          per-thread fetch enable
//   rst_pc_i                            reset PC for every thread (low XLEN bits used)
//   br_mis_valid_i[t], br_mis_target_i  per-thread mispredict and redirect target
//   ic_response_i                       tag granted to this cycle's request (0 = refused)
//   ic_data_i, ic_tag_i                 returned 8-byte line and its tag (0 = no data)
//   dp_num_i                            instructions Dispatch takes this cycle
//   if_ic_command_o/addr/data/size      memory request (line address, data 0, DOUBLE)
//   fiq_dp_*                            dispatch offer: count, thread, pc/npc/inst per slot
//   thread_idx_disp_o_t, thread_to_ft_o_t  selected dispatch / fetch thread
//   thread_data_*_o_t                   per-thread queue pointers, PC and entry contents
module smt_fetch_unit #(
   parameter int THREAD_NUM = 2,
   parameter int FIQ_NUM    = 8,
   parameter int DP_NUM     = 2,
   parameter int XLEN       = 32,
   localparam int TW = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1,
   localparam int FW = $clog2(FIQ_NUM),
   localparam int PW = FW + 1,
   localparam int SW = $clog2(FIQ_NUM + 1),
   localparam int DW = $clog2(DP_NUM + 1)
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic [THREAD_NUM-1:0]                    pc_en_i,
   input  logic [63:0]                              rst_pc_i,
   input  logic [THREAD_NUM-1:0]                    br_mis_valid_i,
   input  logic [THREAD_NUM-1:0][XLEN-1:0]          br_mis_target_i,
   input  logic [3:0]                               ic_response_i,
   input  logic [63:0]                              ic_data_i,
   input  logic [3:0]                               ic_tag_i,
   input  logic [DW-1:0]                            dp_num_i,
   output logic [1:0]                               if_ic_command_o,
   output logic [63:0]                              if_ic_addr_o,
   output logic [63:0]                              if_ic_data_o,
   output logic [1:0]                               if_ic_size_o,
   output logic [DW-1:0]                            fiq_dp_avail_num_o,
   output logic [TW-1:0]                            fiq_dp_thread_idx_o,
   output logic [DP_NUM-1:0][XLEN-1:0]              fiq_dp_pc_o,
   output logic [DP_NUM-1:0][XLEN-1:0]              fiq_dp_npc_o,
   output logic [DP_NUM-1:0][XLEN-1:0]              fiq_dp_inst_o,
   output logic [TW-1:0]                            thread_idx_disp_o_t,
   output logic [TW-1:0]                            thread_to_ft_o_t,
   output logic [THREAD_NUM-1:0][PW-1:0]            thread_data_hd_o_t,
   output logic [THREAD_NUM-1:0][PW-1:0]            thread_data_tail_o_t,
   output logic [THREAD_NUM-1:0][SW-1:0]            thread_data_avail_o_t,
   output logic [THREAD_NUM-1:0][XLEN-1:0]          thread_data_pc_o_t,
   output logic [THREAD_NUM-1:0][FIQ_NUM-1:0][XLEN-1:0] thread_data_buf_pc_o_t,
   output logic [THREAD_NUM-1:0][FIQ_NUM-1:0][XLEN-1:0] thread_data_buf_inst_o_t,
   output logic [THREAD_NUM-1:0][FIQ_NUM-1:0][3:0]  thread_data_buf_tag_o_t,
   output logic [THREAD_NUM-1:0][FIQ_NUM-1:0]       thread_data_buf_bp_o_t
);

   typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} bus_cmd_e;
   localparam logic [1:0] SIZE_DOUBLE = 2'd3;

   // Architectural state
   logic                                     started_q;   // low for the first cycle after reset
   logic [TW-1:0]                            last_fetch_q, last_disp_q;
   logic [THREAD_NUM-1:0][PW-1:0]            hd_q, tail_q;
   logic [THREAD_NUM-1:0][SW-1:0]            avail_q;
   logic [THREAD_NUM-1:0][XLEN-1:0]          pc_q;
   logic [THREAD_NUM-1:0][FIQ_NUM-1:0][XLEN-1:0] buf_pc_q, buf_inst_q;
   logic [THREAD_NUM-1:0][FIQ_NUM-1:0][3:0]  buf_tag_q;   // nonzero = instruction pending
   logic [THREAD_NUM-1:0][FIQ_NUM-1:0]       buf_bp_q;

   logic                                     fetch_vld, disp_vld;
   logic [TW-1:0]                            fetch_thread, disp_thread;
   logic [THREAD_NUM-1:0][DW-1:0]            ready_n;     // contiguous ready entries from head
   logic [THREAD_NUM-1:0][DW-1:0]            dp_take;
   logic [THREAD_NUM-1:0]                    fetch_grant;

   logic unused_rst_pc;
   assign unused_rst_pc = ^rst_pc_i[63:XLEN];

   function automatic logic [TW-1:0] rr_next(input logic [TW-1:0] base, input int off);
      return TW'((int'(base) + off) % THREAD_NUM);
   endfunction

   // Fetch select: round-robin starting after the last granted thread. The
   // pointer only moves on a grant, so a refused request is re-offered unchanged.
   always_comb begin
      logic [TW-1:0] cand;
      fetch_vld    = 1'b0;
      fetch_thread = '0;
      cand         = '0;
      for (int off = 1; off <= THREAD_NUM; off++) begin
         cand = rr_next(last_fetch_q, off);
         if (!fetch_vld && started_q && pc_en_i[cand] && (avail_q[cand] != '0) &&
             !br_mis_valid_i[cand]) begin
            fetch_vld    = 1'b1;
            fetch_thread = cand;
         end
      end
   end

   // Ready-run length per thread, then round-robin dispatch select.
   always_comb begin
      logic          run;
      logic [FW-1:0] slot;
      logic [PW-1:0] cnt;
      logic [TW-1:0] cand;
      ready_n     = '0;
      disp_vld    = 1'b0;
      disp_thread = '0;
      run         = 1'b0;
      slot        = '0;
      cnt         = '0;
      cand        = '0;
      for (int t = 0; t < THREAD_NUM; t++) begin
         run = 1'b1;
         cnt = tail_q[t] - hd_q[t];
         for (int k = 0; k < DP_NUM; k++) begin
            slot = hd_q[t][FW-1:0] + FW'(k);
            if (run && (PW'(k) < cnt) && (buf_tag_q[t][slot] == 4'd0))
               ready_n[t] = ready_n[t] + DW'(1);
            else
               run = 1'b0;
         end
      end
      for (int off = 1; off <= THREAD_NUM; off++) begin
         cand = rr_next(last_disp_q, off);
         if (!disp_vld && (ready_n[cand] != '0) && !br_mis_valid_i[cand]) begin
            disp_vld    = 1'b1;
            disp_thread = cand;
         end
      end
   end

   always_comb begin
      logic [FW-1:0] slot;
      slot               = '0;
      fiq_dp_pc_o        = '0;
      fiq_dp_npc_o       = '0;
      fiq_dp_inst_o      = '0;
      fiq_dp_avail_num_o = disp_vld ? ready_n[disp_thread] : '0;
      for (int k = 0; k < DP_NUM; k++) begin
         slot = hd_q[disp_thread][FW-1:0] + FW'(k);
         if (DW'(k) < fiq_dp_avail_num_o) begin
            fiq_dp_pc_o[k]   = buf_pc_q[disp_thread][slot];
            fiq_dp_npc_o[k]  = buf_pc_q[disp_thread][slot] + XLEN'(4);
            fiq_dp_inst_o[k] = buf_inst_q[disp_thread][slot];
         end
      end
      for (int t = 0; t < THREAD_NUM; t++) begin
         dp_take[t]     = (disp_vld && (disp_thread == TW'(t))) ? dp_num_i : '0;
         fetch_grant[t] = fetch_vld && (fetch_thread == TW'(t)) && (ic_response_i != 4'd0);
      end
   end

   assign fiq_dp_thread_idx_o = disp_thread;
   assign thread_idx_disp_o_t = disp_thread;
   assign thread_to_ft_o_t    = fetch_thread;
   assign if_ic_command_o     = fetch_vld ? BUS_LOAD : BUS_NONE;
   assign if_ic_addr_o        = fetch_vld ? {{(64-XLEN){1'b0}}, pc_q[fetch_thread][XLEN-1:3], 3'b000}
                                          : 64'd0;
   assign if_ic_data_o        = 64'd0;
   assign if_ic_size_o        = SIZE_DOUBLE;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         started_q    <= 1'b0;
         last_fetch_q <= '0;
         last_disp_q  <= '0;
         hd_q         <= '0;
         tail_q       <= '0;
         buf_pc_q     <= '0;
         buf_inst_q   <= '0;
         buf_tag_q    <= '0;
         buf_bp_q     <= '0;
         for (int t = 0; t < THREAD_NUM; t++) begin
            avail_q[t] <= SW'(FIQ_NUM);
            pc_q[t]    <= rst_pc_i[XLEN-1:0];
         end
      end else begin
         started_q <= 1'b1;
         if (fetch_vld && (ic_response_i != 4'd0)) last_fetch_q <= fetch_thread;
         if (disp_vld && (dp_num_i != '0))         last_disp_q  <= disp_thread;
         // Replies first: the new entry written below at tail (possibly carrying
         // the same tag) overrides, so a same-cycle reply only reaches older entries.
         if (ic_tag_i != 4'd0) begin
            for (int t = 0; t < THREAD_NUM; t++) begin
               for (int e = 0; e < FIQ_NUM; e++) begin
                  if (buf_tag_q[t][e] == ic_tag_i) begin
                     buf_inst_q[t][e] <= buf_pc_q[t][e][2] ? ic_data_i[63:32] : ic_data_i[31:0];
                     buf_tag_q[t][e]  <= 4'd0;
                  end
               end
            end
         end
         for (int t = 0; t < THREAD_NUM; t++) begin
            if (br_mis_valid_i[t]) begin
               // Flush wins over everything, including a reply landing this cycle.
               hd_q[t]       <= '0;
               tail_q[t]     <= '0;
               avail_q[t]    <= SW'(FIQ_NUM);
               pc_q[t]       <= br_mis_target_i[t];
               buf_pc_q[t]   <= '0;
               buf_inst_q[t] <= '0;
               buf_tag_q[t]  <= '0;
               buf_bp_q[t]   <= '0;
            end else begin
               if (fetch_grant[t]) begin
                  buf_pc_q[t][tail_q[t][FW-1:0]]   <= pc_q[t];
                  buf_inst_q[t][tail_q[t][FW-1:0]] <= '0;
                  buf_tag_q[t][tail_q[t][FW-1:0]]  <= ic_response_i;
                  buf_bp_q[t][tail_q[t][FW-1:0]]   <= 1'b0;   // static not-taken
                  tail_q[t] <= tail_q[t] + PW'(1);
                  pc_q[t]   <= pc_q[t] + XLEN'(4);
               end
               hd_q[t]    <= hd_q[t] + PW'(dp_take[t]);
               avail_q[t] <= avail_q[t] + SW'(dp_take[t]) - SW'(fetch_grant[t]);
            end
         end
      end
   end

   // Dispatch may never take more than was offered.
   always_ff @(posedge clk_i) begin
      if (!rst_i) assert (dp_num_i <= fiq_dp_avail_num_o);
   end

   assign thread_data_hd_o_t       = hd_q;
   assign thread_data_tail_o_t     = tail_q;
   assign thread_data_avail_o_t    = avail_q;
   assign thread_data_pc_o_t       = pc_q;
   assign thread_data_buf_pc_o_t   = buf_pc_q;
   assign thread_data_buf_inst_o_t = buf_inst_q;
   assign thread_data_buf_tag_o_t  = buf_tag_q;
   assign thread_data_buf_bp_o_t   = buf_bp_q;

endmodule

// File: tb/tb_smt_fetch_unit.sv
// tb_smt_fetch_unit
//   Directed bench for smt_fetch_unit: fill both queues, tagged replies, single
//   dispatch through pointer wrap, mispredict redirect, refused requests, stale
//   replies after a flush, and asynchronous reset in the middle of operation.
module tb_smt_fetch_unit;

   localparam int TN = 2;
   localparam int FN = 8;
   localparam int DN = 2;
   localparam int XL = 32;

   // Clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DUT connections
   logic [TN-1:0]              pc_en;
   logic [63:0]                rst_pc;
   logic [TN-1:0]              br_mis;
   logic [TN-1:0][XL-1:0]      br_target;
   logic [3:0]                 ic_response;
   logic [63:0]                ic_data;
   logic [3:0]                 ic_tag;
   logic [1:0]                 dp_num;
   logic [1:0]                 command;
   logic [63:0]                addr, wdata;
   logic [1:0]                 size;
   logic [1:0]                 avail_num;
   logic                       dp_thread;
   logic [DN-1:0][XL-1:0]      dp_pc, dp_npc, dp_inst;
   logic                       disp_sel, ft_sel;
   logic [TN-1:0][3:0]         hd, tail;
   logic [TN-1:0][3:0]         avail;
   logic [TN-1:0][XL-1:0]      pc_reg;
   logic [TN-1:0][FN-1:0][XL-1:0] buf_pc, buf_inst;
   logic [TN-1:0][FN-1:0][3:0] buf_tag;
   logic [TN-1:0][FN-1:0]      buf_bp;

   smt_fetch_unit dut (
      .clk_i                    (clk),
      .rst_i                    (rst),
      .pc_en_i                  (pc_en),
      .rst_pc_i                 (rst_pc),
      .br_mis_valid_i           (br_mis),
      .br_mis_target_i          (br_target),
      .ic_response_i            (ic_response),
      .ic_data_i                (ic_data),
      .ic_tag_i                 (ic_tag),
      .dp_num_i                 (dp_num),
      .if_ic_command_o          (command),
      .if_ic_addr_o             (addr),
      .if_ic_data_o             (wdata),
      .if_ic_size_o             (size),
      .fiq_dp_avail_num_o       (avail_num),
      .fiq_dp_thread_idx_o      (dp_thread),
      .fiq_dp_pc_o              (dp_pc),
      .fiq_dp_npc_o             (dp_npc),
      .fiq_dp_inst_o            (dp_inst),
      .thread_idx_disp_o_t      (disp_sel),
      .thread_to_ft_o_t         (ft_sel),
      .thread_data_hd_o_t       (hd),
      .thread_data_tail_o_t     (tail),
      .thread_data_avail_o_t    (avail),
      .thread_data_pc_o_t       (pc_reg),
      .thread_data_buf_pc_o_t   (buf_pc),
      .thread_data_buf_inst_o_t (buf_inst),
      .thread_data_buf_tag_o_t  (buf_tag),
      .thread_data_buf_bp_o_t   (buf_bp)
   );

   // Scoreboard counters
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int thr;
      logic [31:0] exp_inst;
      rst = 1'b1; pc_en = '0; rst_pc = 64'd0; br_mis = '0; br_target = '0;
      ic_response = 4'd0; ic_data = 64'd0; ic_tag = 4'd0; dp_num = 2'd0;

      // ---- reset state
      tick(); tick();
      check("rst_cmd",    64'(command),   64'd0);
      check("rst_avnum",  64'(avail_num), 64'd0);
      check("rst_avail0", 64'(avail[0]),  64'd8);
      check("rst_pc1",    64'(pc_reg[1]), 64'd0);
      check("rst_tail0",  64'(tail[0]),   64'd0);
      check("rst_size",   64'(size),      64'd3);
      check("rst_ftsel",  64'(ft_sel),    64'd0);

      // first cycle after release stays idle
      pc_en = 2'b11; rst = 1'b0; #1;
      check("first_cycle_cmd", 64'(command), 64'd0);

      // ---- fill both queues: thread 1 first, then alternate; tag = 1 + 2*line + thread
      for (int k = 0; k < 16; k++) begin
         tick();
         thr = (k % 2 == 0) ? 1 : 0;
         ic_response = 4'(1 + 2 * (k / 4) + thr);
         #1;
         check("fill_cmd",    64'(command), 64'd1);
         check("fill_addr",   addr,         64'(8 * (k / 4)));
         check("fill_thread", 64'(ft_sel),  64'(thr));
      end
      tick();
      ic_response = 4'd0; #1;
      check("full_cmd",    64'(command),   64'd0);
      check("full_avail0", 64'(avail[0]),  64'd0);
      check("full_avail1", 64'(avail[1]),  64'd0);
      check("full_pc0",    64'(pc_reg[0]), 64'd32);
      check("full_pc1",    64'(pc_reg[1]), 64'd32);
      check("full_tail1",  64'(tail[1]),   64'h8);
      check("full_tag",    64'(buf_tag[1][2]), 64'd4);
      check("full_avnum",  64'(avail_num), 64'd0);

      // ---- reply tag 1 fills thread 0 pc 0 and pc 4
      pc_en = 2'b00; ic_tag = 4'd1; ic_data = 64'h0000_BBBB_0000_AAAA;
      tick();
      ic_tag = 4'd0; #1;
      check("reply_inst0", 64'(buf_inst[0][0]), 64'h0000_AAAA);
      check("reply_inst1", 64'(buf_inst[0][1]), 64'h0000_BBBB);
      check("reply_tag0",  64'(buf_tag[0][0]),  64'd0);
      check("reply_t1tag", 64'(buf_tag[1][0]),  64'd2);
      check("reply_avnum", 64'(avail_num),      64'd2);
      check("reply_dpthr", 64'(dp_thread),      64'd0);
      check("reply_dpins", 64'(dp_inst[0]),     64'h0000_AAAA);
      check("reply_dppc1", 64'(dp_pc[1]),       64'd4);
      check("reply_npc0",  64'(dp_npc[0]),      64'd4);
      check("reply_bp",    64'(buf_bp[0][0]),   64'd0);

      // remaining thread 0 lines: inst for pc p is 0x1000 + p
      for (int l = 1; l < 4; l++) begin
         ic_tag  = 4'(1 + 2 * l);
         ic_data = {32'(32'h1000 + 8 * l + 4), 32'(32'h1000 + 8 * l)};
         tick();
      end
      ic_tag = 4'd0;

      // ---- dispatch one per cycle through pointer wrap
      for (int i = 0; i < 8; i++) begin
         dp_num = 2'd1; #1;
         exp_inst = (i == 0) ? 32'h0000_AAAA : (i == 1) ? 32'h0000_BBBB : 32'(32'h1000 + 4 * i);
         check("dq_avnum", 64'(avail_num), 64'((8 - i >= 2) ? 2 : 1));
         check("dq_pc",    64'(dp_pc[0]),  64'(4 * i));
         check("dq_inst",  64'(dp_inst[0]), 64'(exp_inst));
         tick();
         dp_num = 2'd0;
         check("dq_hd",    64'(hd[0]),    64'(i + 1));
         check("dq_avail", 64'(avail[0]), 64'(i + 1));
      end
      #1;
      check("dq_wrap_hd", 64'(hd[0]),     64'h8);
      check("dq_empty",   64'(avail_num), 64'd0);

      // ---- mispredict thread 0 to pc 4; thread 1 stays full and untouched
      pc_en = 2'b11; br_mis = 2'b01; br_target[0] = 32'd4; br_target[1] = 32'h999; #1;
      check("mis_cmd", 64'(command), 64'd0);
      tick();
      br_mis = 2'b00; #1;
      check("mis_hd0",    64'(hd[0]),     64'd0);
      check("mis_tail0",  64'(tail[0]),   64'd0);
      check("mis_avail0", 64'(avail[0]),  64'd8);
      check("mis_pc0",    64'(pc_reg[0]), 64'd4);
      check("mis_inst0",  64'(buf_inst[0][0]), 64'd0);
      check("mis_tail1",  64'(tail[1]),   64'h8);
      check("mis_pc1",    64'(pc_reg[1]), 64'd32);
      check("mis_ldcmd",  64'(command),   64'd1);
      check("mis_ldaddr", addr,           64'd0);
      check("mis_ldthr",  64'(ft_sel),    64'd0);
      ic_response = 4'd9;
      tick();
      ic_response = 4'd0; #1;
      check("grant_tail0", 64'(tail[0]),      64'd1);
      check("grant_pc0",   64'(pc_reg[0]),    64'd8);
      check("grant_bpc",   64'(buf_pc[0][0]), 64'd4);
      check("grant_btag",  64'(buf_tag[0][0]), 64'd9);

      // ---- refused requests hold
      for (int r = 0; r < 3; r++) begin
         check("refuse_cmd",  64'(command), 64'd1);
         check("refuse_addr", addr,         64'd8);
         tick();
         check("refuse_pc",   64'(pc_reg[0]), 64'd8);
         check("refuse_tail", 64'(tail[0]),   64'd1);
      end
      ic_response = 4'd10;
      tick();
      ic_response = 4'd0; pc_en = 2'b00; #1;
      check("retry_tail", 64'(tail[0]),   64'd2);
      check("retry_pc",   64'(pc_reg[0]), 64'd12);

      // reply tag 9: pc 4 selects upper word
      ic_tag = 4'd9; ic_data = 64'h1111_2222_3333_4444;
      tick();
      ic_tag = 4'd0; #1;
      check("hi_inst",  64'(buf_inst[0][0]), 64'h1111_2222);
      check("hi_avnum", 64'(avail_num),      64'd1);
      check("hi_dpthr", 64'(dp_thread),      64'd0);
      check("hi_dpins", 64'(dp_inst[0]),     64'h1111_2222);
      check("hi_dppc",  64'(dp_pc[0]),       64'd4);

      // ---- mispredict both threads, then stale replies for tags 10 and 2
      br_mis = 2'b11; br_target[0] = 32'h100; br_target[1] = 32'h200;
      tick();
      br_mis = 2'b00; ic_tag = 4'd10; ic_data = 64'hDEAD_BEEF_CAFE_F00D;
      tick();
      ic_tag = 4'd2;
      tick();
      ic_tag = 4'd0; #1;
      check("stale_inst01", 64'(buf_inst[0][1]), 64'd0);
      check("stale_tag01",  64'(buf_tag[0][1]),  64'd0);
      check("stale_inst10", 64'(buf_inst[1][0]), 64'd0);
      check("stale_tail1",  64'(tail[1]),        64'd0);
      check("stale_avail1", 64'(avail[1]),       64'd8);
      check("stale_avnum",  64'(avail_num),      64'd0);
      check("stale_pc0",    64'(pc_reg[0]),      64'h100);
      check("stale_pc1",    64'(pc_reg[1]),      64'h200);

      // ---- asynchronous reset in the middle of a cycle
      rst_pc = 64'h40; pc_en = 2'b11; #1;
      rst = 1'b1; #1;
      check("arst_pc0",  64'(pc_reg[0]), 64'h40);
      check("arst_pc1",  64'(pc_reg[1]), 64'h40);
      check("arst_cmd",  64'(command),   64'd0);
      tick(); tick();
      rst = 1'b0; #1;
      check("arst_first_cmd", 64'(command), 64'd0);
      tick();
      check("arst_ld_cmd",  64'(command), 64'd1);
      check("arst_ld_addr", addr,         64'h40);
      check("arst_ld_thr",  64'(ft_sel),  64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
